// File: rtl/rtc_edit_pkg.sv
// Shared types and constants for the RTC date/time editing controller:
// FSM state encoding, field indices and per-field BCD bounds.
package rtc_edit_pkg;

   localparam int REC_W      = 48;
   localparam int NUM_FIELDS = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EDIT  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam logic [2:0] F_HH = 3'd0;
   localparam logic [2:0] F_MM = 3'd1;
   localparam logic [2:0] F_SS = 3'd2;
   localparam logic [2:0] F_DD = 3'd3;
   localparam logic [2:0] F_MO = 3'd4;
   localparam logic [2:0] F_YY = 3'd5;

   // Entries 6 and 7 are padding so a 3-bit field index always lands in range.
   localparam logic [7:0] FIELD_MIN [0:7] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
   localparam logic [7:0] FIELD_MAX [0:7] = '{8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 8'h99, 8'h00, 8'h00};

   function automatic logic [2:0] field_next(input logic [2:0] f);
      return (f == F_YY) ? F_HH : f + 3'd1;
   endfunction

   function automatic logic [2:0] field_prev(input logic [2:0] f);
      return (f == F_HH) ? F_YY : f - 3'd1;
   endfunction

endpackage

// File: rtl/rtc_edit_ctrl_bcd_field_step.sv
// Combinational one-step BCD increment/decrement of a single date/time field,
// wrapping between min and max and clamping out-of-range values to min.
module bcd_field_step (
   input  logic [7:0] value,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   input  logic       up,
   output logic [7:0] next_val
);

   logic valid;

   // A value with a non-decimal nibble is treated as out of range as well.
   assign valid = (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) &&
                  (value >= min_val) && (value <= max_val);

   always_comb begin
      next_val = min_val;
      if (valid) begin
         if (up) begin
            if (value == max_val)
               next_val = min_val;
            else if (value[3:0] == 4'd9)
               next_val = {value[7:4] + 4'd1, 4'd0};
            else
               next_val = value + 8'd1;
         end else begin
            if (value == min_val)
               next_val = max_val;
            else if (value[3:0] == 4'd0)
               next_val = {value[7:4] - 4'd1, 4'd9};
            else
               next_val = value - 8'd1;
         end
      end
   end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Keyboard-driven date/time editing session with req/ack hand-off of the edited
// BCD record. Optional EDIT inactivity abort enabled by RTC_EDIT_TIMEOUT_EN.
module rtc_edit_ctrl
   import rtc_edit_pkg::*;
`ifdef RTC_EDIT_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
   parameter int unsigned TO_W           = 30
)
`endif
(
   input  logic             Clock_i,
   input  logic             Reset_i,
   input  logic             izq_i,
   input  logic             der_i,
   input  logic             arriba_i,
   input  logic             abajo_i,
   input  logic             ent_i,
   input  logic [REC_W-1:0] cur_data_i,
   input  logic             wr_ack_i,
   output logic             edit_o,
   output logic [2:0]       field_o,
   output logic [REC_W-1:0] edit_data_o,
   output logic             wr_req_o,
   output logic             abort_o,
   output logic [1:0]       state_dbg_o
);

   state_t          state;
   logic [5:0][7:0] rec;
   logic [5:0][7:0] rec_stepped;
   logic [2:0]      field;
   logic [2:0]      byte_idx;
   logic [7:0]      step_val;
   logic            to_hit;

   // Field 0 (hh) occupies the most significant byte of the record.
   assign byte_idx = 3'(NUM_FIELDS - 1) - field;

   bcd_field_step u_step (
      .value    (rec[byte_idx]),
      .min_val  (FIELD_MIN[field]),
      .max_val  (FIELD_MAX[field]),
      .up       (arriba_i),
      .next_val (step_val)
   );

   always_comb begin
      rec_stepped           = rec;
      rec_stepped[byte_idx] = step_val;
   end

`ifdef RTC_EDIT_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic            any_key;

   assign any_key = izq_i | der_i | arriba_i | abajo_i | ent_i;
   assign to_hit  = (state == EDIT) && !any_key &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clock_i) begin
      if (!Reset_i)
         to_cnt <= '0;
      else if ((state != EDIT) || any_key || to_hit)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge Clock_i) begin
      if (!Reset_i) begin
         state    <= IDLE;
         edit_o   <= 1'b0;
         field    <= F_HH;
         rec      <= '0;
         wr_req_o <= 1'b0;
         abort_o  <= 1'b0;
      end else begin
         abort_o <= 1'b0;
         case (state)
            IDLE: begin
               rec <= cur_data_i;
               if (ent_i) begin
                  state  <= EDIT;
                  edit_o <= 1'b1;
                  field  <= F_HH;
               end
            end
            EDIT: begin
               // One action per cycle: ent > arriba > abajo > der > izq.
               if (ent_i) begin
                  state    <= WRITE;
                  wr_req_o <= 1'b1;
               end else if (arriba_i || abajo_i) begin
                  rec <= rec_stepped;
               end else if (der_i) begin
                  field <= field_next(field);
               end else if (izq_i) begin
                  field <= field_prev(field);
               end else if (to_hit) begin
                  state   <= IDLE;
                  edit_o  <= 1'b0;
                  field   <= F_HH;
                  abort_o <= 1'b1;
               end
            end
            WRITE: begin
               if (wr_ack_i) begin
                  state    <= IDLE;
                  edit_o   <= 1'b0;
                  wr_req_o <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               edit_o   <= 1'b0;
               wr_req_o <= 1'b0;
            end
         endcase
      end
   end

   assign field_o     = field;
   assign edit_data_o = rec;
   assign state_dbg_o = state;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Self-checking bench for rtc_edit_ctrl: directed edit sessions plus random
// key/ack traffic against a decimal-arithmetic model of the editing rules.
module tb_rtc_edit_ctrl;

   logic        Clock_i = 1'b0;
   logic        Reset_i = 1'b0;
   logic        izq_i = 1'b0, der_i = 1'b0, arriba_i = 1'b0, abajo_i = 1'b0, ent_i = 1'b0;
   logic [47:0] cur_data_i = '0;
   logic        wr_ack_i = 1'b0;
   logic        edit_o;
   logic [2:0]  field_o;
   logic [47:0] edit_data_o;
   logic        wr_req_o;
   logic        abort_o;
   logic [1:0]  state_dbg_o;

   localparam logic [4:0] K_NONE = 5'b00000;
   localparam logic [4:0] K_IZQ  = 5'b00001;
   localparam logic [4:0] K_DER  = 5'b00010;
   localparam logic [4:0] K_ABJ  = 5'b00100;
   localparam logic [4:0] K_ARR  = 5'b01000;
   localparam logic [4:0] K_ENT  = 5'b10000;

`ifdef RTC_EDIT_TIMEOUT_EN
   localparam int TO_CYC = 16;
   rtc_edit_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(30)) dut (
`else
   rtc_edit_ctrl dut (
`endif
      .Clock_i(Clock_i), .Reset_i(Reset_i),
      .izq_i(izq_i), .der_i(der_i), .arriba_i(arriba_i), .abajo_i(abajo_i), .ent_i(ent_i),
      .cur_data_i(cur_data_i), .wr_ack_i(wr_ack_i),
      .edit_o(edit_o), .field_o(field_o), .edit_data_o(edit_data_o),
      .wr_req_o(wr_req_o), .abort_o(abort_o), .state_dbg_o(state_dbg_o)
   );

   // ---------------- clock / reset ----------------
   always #5 Clock_i = ~Clock_i;

   // ---------------- scoreboard / model ----------------
   int checks = 0;
   int errors = 0;
   logic [47:0] exp_q[$];

   int          m_mode;    // 0 browsing, 1 editing, 2 waiting for write ack
   int          m_field;
   logic [47:0] m_rec;
   bit          m_req, m_abort;
   int          m_quiet;
   bit          pop_due;
   logic [47:0] pop_val;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int n);
      logic [3:0] hi, lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   function automatic int fmin(input int f);
      return (f == 3 || f == 4) ? 1 : 0;
   endfunction

   function automatic int fmax(input int f);
      case (f)
         0: return 23;
         1, 2: return 59;
         3: return 31;
         4: return 12;
         default: return 99;
      endcase
   endfunction

   function automatic logic [7:0] adjust(input logic [7:0] b, input int f, input bit up);
      int n;
      n = bcd2int(b);
      if (b[7:4] > 9 || b[3:0] > 9 || n < fmin(f) || n > fmax(f)) return int2bcd(fmin(f));
      if (up) n = (n == fmax(f)) ? fmin(f) : n + 1;
      else    n = (n == fmin(f)) ? fmax(f) : n - 1;
      return int2bcd(n);
   endfunction

   function automatic logic [7:0] get_f(input logic [47:0] r, input int f);
      return 8'(r >> (8 * (5 - f)));
   endfunction

   function automatic logic [47:0] put_f(input logic [47:0] r, input int f, input logic [7:0] v);
      logic [47:0] mask;
      mask = 48'hFF << (8 * (5 - f));
      return (r & ~mask) | (48'(v) << (8 * (5 - f)));
   endfunction

   task automatic model_edge(input logic [4:0] k, input logic ack, input logic rst_n);
      m_abort = 0;
      pop_due = 0;
      if (!rst_n) begin
         m_mode = 0; m_field = 0; m_rec = '0; m_req = 0; m_quiet = 0;
         exp_q.delete();
         return;
      end
      case (m_mode)
         0: begin
            m_rec = cur_data_i;
            if (k[4]) begin m_mode = 1; m_field = 0; m_quiet = 0; end
         end
         1: begin
            if (k[4]) begin
               m_mode = 2; m_req = 1; exp_q.push_back(m_rec);
            end else if (k[3]) m_rec = put_f(m_rec, m_field, adjust(get_f(m_rec, m_field), m_field, 1));
            else if (k[2]) m_rec = put_f(m_rec, m_field, adjust(get_f(m_rec, m_field), m_field, 0));
            else if (k[1]) m_field = (m_field + 1) % 6;
            else if (k[0]) m_field = (m_field + 5) % 6;
`ifdef RTC_EDIT_TIMEOUT_EN
            if (k != 0) m_quiet = 0;
            else if (m_quiet == TO_CYC - 1) begin
               m_abort = 1; m_mode = 0; m_field = 0; m_quiet = 0;
            end else m_quiet++;
`endif
         end
         default: begin
            if (ack) begin
               m_req = 0; m_mode = 0;
               if (exp_q.size() > 0) begin pop_val = exp_q.pop_front(); pop_due = 1; end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("edit_o", 64'(edit_o), 64'(m_mode != 0));
      check("field_o", 64'(field_o), 64'(m_field));
      check("edit_data_o", 64'(edit_data_o), 64'(m_rec));
      check("wr_req_o", 64'(wr_req_o), 64'(m_req));
      check("abort_o", 64'(abort_o), 64'(m_abort));
      if (pop_due) check("written_rec", 64'(edit_data_o), 64'(pop_val));
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input logic [4:0] k, input logic ack, input logic rst_n);
      {ent_i, arriba_i, abajo_i, der_i, izq_i} = k;
      wr_ack_i = ack;
      Reset_i  = rst_n;
      @(posedge Clock_i);
      model_edge(k, ack, rst_n);
      #1;
      compare_all();
   endtask

   function automatic logic [47:0] rand_rec();
      logic [47:0] r;
      r = '0;
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 1) == 1)
            r = put_f(r, f, int2bcd($urandom_range(fmin(f), fmax(f))));
         else
            r = put_f(r, f, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
      end
      return r;
   endfunction

   initial begin
      logic [47:0] held;
      logic [4:0]  k;
      int          pct;

      // reset
      cyc(K_NONE, 0, 0);
      cyc(K_NONE, 0, 0);
      check("rst_data", 64'(edit_data_o), 64'h0);
      check("rst_state", 64'(state_dbg_o), 64'd0);

      // IDLE tracking
      cur_data_i = 48'h12_34_56_15_06_16;
      cyc(K_NONE, 0, 1);
      check("idle_track", 64'(edit_data_o), 64'h12_34_56_15_06_16);
      check("idle_edit", 64'(edit_o), 64'd0);
      check("idle_req", 64'(wr_req_o), 64'd0);
      cyc(K_DER | K_ARR, 1, 1);
      check("idle_keys_ignored", 64'(field_o), 64'd0);

      // directed edit session
      cur_data_i = 48'h00_59_56_01_09_16;
      cyc(K_NONE, 0, 1);
      cyc(K_ENT, 0, 1);
      check("enter_edit", 64'(edit_o), 64'd1);
      cur_data_i = 48'h11_11_11_11_11_11;
      cyc(K_ABJ, 0, 1);
      check("hh_wrap_down", 64'(edit_data_o[47:40]), 64'h23);
      cyc(K_ARR, 0, 1);
      cyc(K_ARR, 0, 1);
      check("hh_wrap_up", 64'(edit_data_o[47:40]), 64'h01);
      for (int i = 0; i < 6; i++) cyc(K_DER, 0, 1);
      check("field_wrap", 64'(field_o), 64'd0);
      cyc(K_IZQ, 0, 1);
      check("field_wrap_left", 64'(field_o), 64'd5);
      cyc(K_DER, 0, 1);
      cyc(K_DER, 0, 1);
      cyc(K_ARR, 0, 1);
      check("mm_wrap", 64'(edit_data_o[39:32]), 64'h00);
      cyc(K_DER, 0, 1);
      cyc(K_DER, 0, 1);
      cyc(K_ABJ, 0, 1);
      check("dd_wrap", 64'(edit_data_o[23:16]), 64'h31);
      cyc(K_DER, 0, 1);
      cyc(K_ARR, 0, 1);
      check("mo_carry", 64'(edit_data_o[15:8]), 64'h10);
      cyc(K_ARR | K_DER, 0, 1);
      check("prio_arr_der_val", 64'(edit_data_o[15:8]), 64'h11);
      check("prio_arr_der_fld", 64'(field_o), 64'd4);
      cyc(K_ENT, 0, 1);
      check("write_req", 64'(wr_req_o), 64'd1);
      held = edit_data_o;
      for (int i = 0; i < 20; i++) cyc(5'($urandom_range(0, 31)), 0, 1);
      check("write_hold_data", 64'(edit_data_o), 64'(held));
      check("write_hold_req", 64'(wr_req_o), 64'd1);
      cyc(K_NONE, 1, 1);
      check("ack_req", 64'(wr_req_o), 64'd0);
      check("ack_edit", 64'(edit_o), 64'd0);

      // clamp of out-of-range loaded value, then reset mid-WRITE
      cur_data_i = 48'h25_00_00_01_01_00;
      cyc(K_ENT, 0, 1);
      cyc(K_ARR, 0, 1);
      check("hh_clamp", 64'(edit_data_o[47:40]), 64'h00);
      cyc(K_ENT, 0, 1);
      cyc(K_NONE, 0, 0);
      check("midwrite_rst_req", 64'(wr_req_o), 64'd0);
      check("midwrite_rst_edit", 64'(edit_o), 64'd0);
      check("midwrite_rst_data", 64'(edit_data_o), 64'h0);
      cyc(K_NONE, 1, 1);
      check("stray_ack", 64'(edit_o), 64'd0);

`ifdef RTC_EDIT_TIMEOUT_EN
      cyc(K_ENT, 0, 1);
      for (int i = 0; i < TO_CYC - 1; i++) cyc(K_NONE, 0, 1);
      check("to_not_yet", 64'(abort_o), 64'd0);
      cyc(K_NONE, 0, 1);
      check("to_abort", 64'(abort_o), 64'd1);
      check("to_idle", 64'(edit_o), 64'd0);
      check("to_no_req", 64'(wr_req_o), 64'd0);
      cyc(K_NONE, 0, 1);
      check("to_pulse_end", 64'(abort_o), 64'd0);
`endif

      // random traffic
      pct = 5;
      for (int c = 0; c < 3000; c++) begin
         if (c % 50 == 0) pct = ($urandom_range(0, 1) == 1) ? 30 : 5;
         if ($urandom_range(0, 9) == 0) cur_data_i = rand_rec();
         k = ($urandom_range(0, 99) < pct) ? 5'($urandom_range(1, 31)) : K_NONE;
         if (k[4] && $urandom_range(0, 2) != 0) k[4] = 1'b0;
         cyc(k, ($urandom_range(0, 99) < ((m_mode == 2) ? 20 : 3)) ? 1'b1 : 1'b0,
             ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1);
      end

      {ent_i, arriba_i, abajo_i, der_i, izq_i} = K_NONE;
      wr_ack_i = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
